// File: rtl/pooling_backward_sched_pkg.sv
// Shared types for the pooling backward scheduler.
// Optional perf counters are enabled with POOL_BWD_PERF_CNT_EN.
package pooling_pkg;

  typedef logic [31:0] word_t;

  localparam int IDX_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_WAIT_DP,
    S_OUT,
    S_DONE
  } pool_bwd_state_e;

  function automatic int win_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pooling_backward_sched_if.sv
// Window-in / result-out valid/ready streams of the scheduler.
// master = stream environment, slave = scheduler.
interface pooling_backward_sched_if
  import pooling_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int WIN_W = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [IDX_W-1:0]     in_idx;
  word_t                in_err;
  word_t [WIDTH-1:0]    in_vect;

  logic                 out_valid;
  logic                 out_ready;
  word_t [WIDTH-1:0]    out_vect;
  logic [WIN_W-1:0]     out_win;

  modport slave (
    input  in_valid, in_idx, in_err, in_vect,
    input  out_ready,
    output in_ready,
    output out_valid, out_vect, out_win
  );

  modport master (
    output in_valid, in_idx, in_err, in_vect,
    output out_ready,
    input  in_ready,
    input  out_valid, out_vect, out_win
  );

endinterface

// File: rtl/pooling_backward_sched_lat_cnt.sv
// Loadable down-counter with zero flag for the datapath latency wait.
// Stops at zero; load has priority over decrement.
module pool_bwd_lat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pooling_backward_sched.sv
// One-window-at-a-time sequencer for the pooling backward datapath.
// `define POOL_BWD_PERF_CNT_EN adds stall_in_cnt / stall_out_cnt.
module pooling_backward_sched
  import pooling_pkg::*;
#(
  parameter int K_W         = 3,
  parameter int K_H         = 3,
  parameter int WIDTH       = K_W * K_H,
  parameter int DP_LATENCY  = 8,
  parameter int NUM_WINDOWS = 16,
  localparam int WIN_W      = win_w(NUM_WINDOWS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  pooling_backward_sched_if.slave io,
  output logic [IDX_W-1:0]    dp_idx,
  output word_t               dp_err,
  output word_t [WIDTH-1:0]   dp_vect,
  input  word_t [WIDTH-1:0]   dp_result,
  output logic                idx_err
`ifdef POOL_BWD_PERF_CNT_EN
  ,
  output word_t               stall_in_cnt,
  output word_t               stall_out_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_WINDOWS + 1);
  localparam int LAT_W = $clog2(DP_LATENCY + 1);

  pool_bwd_state_e  state;
  pool_bwd_state_e  state_nxt;
  logic [CNT_W-1:0] win_cnt;
  logic             lat_zero;
  logic             hs_in;
  logic             hs_out;
  logic             last_win;
  logic             bad_idx;
  logic             go;

  assign go       = (state == S_IDLE) && start;
  assign hs_in    = io.in_valid && io.in_ready;
  assign hs_out   = io.out_valid && io.out_ready;
  assign last_win = (win_cnt == CNT_W'(NUM_WINDOWS - 1));
  assign bad_idx  = ({24'd0, io.in_idx} >= 32'(WIDTH));

  pool_bwd_lat_cnt #(
    .W (LAT_W)
  ) u_lat (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (hs_in),
    .load_val (LAT_W'(DP_LATENCY - 1)),
    .dec      (state == S_WAIT_DP),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start)    state_nxt = S_WAIT_IN;
      S_WAIT_IN: if (hs_in)    state_nxt = S_WAIT_DP;
      S_WAIT_DP: if (lat_zero) state_nxt = S_OUT;
      S_OUT: begin
        if (hs_out) state_nxt = last_win ? S_DONE : S_WAIT_IN;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    unique case (1'b1)
      (state == S_WAIT_IN): begin
        busy        = 1'b1;
        io.in_ready = 1'b1;
      end
      (state == S_WAIT_DP): busy = 1'b1;
      (state == S_OUT): begin
        busy         = 1'b1;
        io.out_valid = 1'b1;
      end
      (state == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  // Out-of-range index zeroes the error term so the vector passes through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_idx      <= '0;
      dp_err      <= '0;
      dp_vect     <= '0;
      io.out_vect <= '0;
      io.out_win  <= '0;
      win_cnt     <= '0;
      idx_err     <= 1'b0;
    end else begin
      if (go) begin
        win_cnt <= '0;
        idx_err <= 1'b0;
      end
      if (hs_in) begin
        dp_idx  <= io.in_idx;
        dp_vect <= io.in_vect;
        dp_err  <= bad_idx ? '0 : io.in_err;
        if (bad_idx) idx_err <= 1'b1;
      end
      if (state == S_WAIT_DP && lat_zero) begin
        io.out_vect <= dp_result;
        io.out_win  <= win_cnt[WIN_W-1:0];
      end
      if (hs_out) win_cnt <= win_cnt + 1'b1;
    end
  end

`ifdef POOL_BWD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_in_cnt  <= '0;
      stall_out_cnt <= '0;
    end else if (go) begin
      stall_in_cnt  <= '0;
      stall_out_cnt <= '0;
    end else begin
      if (state == S_WAIT_IN && !io.in_valid && stall_in_cnt != '1)
        stall_in_cnt <= stall_in_cnt + 1'b1;
      if (state == S_OUT && !io.out_ready && stall_out_cnt != '1)
        stall_out_cnt <= stall_out_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pooling_backward_sched.sv
// Randomized self-checking bench for pooling_backward_sched.
// Includes a delayed behavioural model of the pooling backward datapath.
module tb_pooling_backward_sched;
  import pooling_pkg::*;

  localparam int WIDTH = 9;
  localparam int DPL   = 8;
  localparam int NW    = 16;
  localparam int WIN_W = 4;

  typedef word_t [WIDTH-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, idx_err;
  logic [7:0] dp_idx;
  word_t      dp_err;
  vec_t       dp_vect, dp_result;
`ifdef POOL_BWD_PERF_CNT_EN
  word_t      sic, soc;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  pooling_backward_sched_if #(.WIDTH(WIDTH), .WIN_W(WIN_W)) bus ();

  pooling_backward_sched #(
    .K_W(3), .K_H(3), .DP_LATENCY(DPL), .NUM_WINDOWS(NW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .io        (bus.slave),
    .dp_idx    (dp_idx),
    .dp_err    (dp_err),
    .dp_vect   (dp_vect),
    .dp_result (dp_result),
    .idx_err   (idx_err)
`ifdef POOL_BWD_PERF_CNT_EN
    ,
    .stall_in_cnt  (sic),
    .stall_out_cnt (soc)
`endif
  );

  // Datapath: scatter err into the max position, DPL-1 register stages.
  function automatic vec_t dp_fn(input logic [7:0] idx, input word_t err,
                                 input vec_t v);
    vec_t o;
    for (int i = 0; i < WIDTH; i++)
      o[i] = v[i] + ((i == int'(idx)) ? err : 32'd0);
    return o;
  endfunction

  vec_t pipe [DPL-1];
  initial for (int i = 0; i < DPL - 1; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= dp_fn(dp_idx, dp_err, dp_vect);
    for (int i = 1; i < DPL - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_result = pipe[DPL-2];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Expected result: gradient added at the max index, vector unchanged if
  // the index lies outside the window.
  function automatic vec_t ref_out(input logic [7:0] idx, input word_t err,
                                   input vec_t v);
    vec_t r;
    r = v;
    if (int'(idx) < WIDTH) r[idx] = r[idx] + err;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < WIDTH; i++) r[i] = $urandom;
    return r;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1 || idx_err !== 1'b0) begin
      errors++;
      $display("FAIL start: busy=%b in_ready=%b idx_err=%b want 1 1 0",
               busy, bus.in_ready, idx_err);
    end
  endtask

  task automatic do_window(input logic [7:0] idx, input word_t err,
                           input vec_t v, input int bp, input int exp_win,
                           input bit poke_start);
    vec_t  exp;
    word_t exp_err;
    int    acc, n;
    bit    hold_ok, bp_ok;
    exp     = ref_out(idx, err, v);
    exp_err = (int'(idx) >= WIDTH) ? 32'd0 : err;
    bus.out_ready = (bp == 0);
    bus.in_valid  = 1'b1;
    bus.in_idx    = idx;
    bus.in_err    = err;
    bus.in_vect   = v;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout win=%0d in_ready=%b want 1",
               exp_win, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_idx   = 8'($urandom);
    bus.in_err   = $urandom;
    bus.in_vect  = rand_vec();
    hold_ok = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready || dp_idx !== idx || dp_err !== exp_err ||
          dp_vect !== v)
        hold_ok = 1'b0;
      start = poke_start && (n == 2);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL dp_hold win=%0d dp_idx=%h dp_err=%h want %h %h",
               exp_win, dp_idx, dp_err, idx, exp_err);
    end
    checks++;
    if (cyc - acc !== DPL + 1) begin
      errors++;
      $display("FAIL latency win=%0d got=%0d want=%0d",
               exp_win, cyc - acc, DPL + 1);
    end
    checks++;
    if (bus.out_vect !== exp) begin
      errors++;
      $display("FAIL out_vect win=%0d got=%h want=%h",
               exp_win, bus.out_vect, exp);
    end
    checks++;
    if (bus.out_win !== WIN_W'(exp_win)) begin
      errors++;
      $display("FAIL out_win got=%0d want=%0d", bus.out_win, exp_win);
    end
    bp_ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.out_vect !== exp ||
          bus.out_win !== WIN_W'(exp_win))
        bp_ok = 1'b0;
    end
    if (bp > 0) begin
      checks++;
      if (!bp_ok) begin
        errors++;
        $display("FAIL backpressure win=%0d out_valid=%b in_ready=%b want 1 0",
                 exp_win, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_release win=%0d out_valid=%b want 0",
               exp_win, bus.out_valid);
    end
    checks++;
    if (exp_win == NW - 1) begin
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse done=%b busy=%b want 1 0", done, busy);
      end
    end else if (done !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL next_win win=%0d done=%b busy=%b in_ready=%b want 0 1 1",
               exp_win, done, busy, bus.in_ready);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.out_valid !== 1'b0 || idx_err !== 1'b0 || dp_idx !== '0 ||
        dp_err !== '0 || dp_vect !== '0 || bus.out_vect !== '0 ||
        bus.out_win !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b in_rdy=%b out_vld=%b ierr=%b dp_idx=%h dp_err=%h win=%0d want all 0",
               tag, busy, done, bus.in_ready, bus.out_valid, idx_err,
               dp_idx, dp_err, bus.out_win);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic map_end(input bit exp_ierr, input int d0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || idx_err !== exp_ierr ||
        done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL map_end: done=%b busy=%b idx_err=%b pulses=%0d want 0 0 %b 1",
               done, busy, idx_err, done_cnt - d0, exp_ierr);
    end
  endtask

  task automatic test_full_map();
    int d0;
    d0 = done_cnt;
    pulse_start();
    for (int n = 0; n < NW; n++)
      do_window(8'(n % 9), $urandom, rand_vec(), 0, n, 1'b0);
    map_end(1'b0, d0);
  endtask

  task automatic test_bad_idx_backpressure();
    int   d0;
    vec_t kv;
    for (int k = 0; k < WIDTH; k++) kv[k] = k;
    d0 = done_cnt;
    pulse_start();
    do_window(8'd4, 32'h0001_0000, '0, 0, 0, 1'b0);
    do_window(8'd9, 32'h0002_0000, kv, 0, 1, 1'b0);
    checks++;
    if (idx_err !== 1'b1) begin
      errors++;
      $display("FAIL idx_err_set got=%b want 1", idx_err);
    end
    do_window(8'($urandom_range(0, 8)), $urandom, rand_vec(), 20, 2, 1'b0);
    do_window(8'($urandom_range(0, 8)), $urandom, rand_vec(), 0, 3, 1'b1);
    do_window(8'($urandom_range(10, 255)), $urandom, rand_vec(), 3, 4, 1'b0);
    for (int n = 5; n < NW; n++)
      do_window(8'($urandom_range(0, 8)), $urandom, rand_vec(),
                int'($urandom_range(0, 2)), n, 1'b0);
    map_end(1'b1, d0);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int n = 0; n < 3; n++)
      do_window(8'($urandom_range(0, 8)), $urandom, rand_vec(), 0, n, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_idx   = 8'd1;
    bus.in_err   = $urandom;
    bus.in_vect  = rand_vec();
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_all_zero("idle_after_mid_reset");
    pulse_start();
    do_window(8'($urandom_range(0, 8)), $urandom, rand_vec(), 0, 0, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_err    = '0;
    bus.in_vect   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_full_map();
    test_bad_idx_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
